// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter sharing one SDRAM controller word interface.
// Optional watchdog on outstanding transactions: define SDRAM_ARB_WATCHDOG_EN.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH     = 21,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s0_valid,
  output logic                    s0_ready,
  input  logic [ADDR_WIDTH-1:0]   s0_addr,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  input  logic                    s1_valid,
  output logic                    s1_ready,
  input  logic [ADDR_WIDTH-1:0]   s1_addr,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;
  logic   winner;
  logic   expire;
  logic   done;

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter holds 0 while IDLE, so it is already clear on entry to BUSY.
  assign cnt_d  = (state_q == BUSY) ? cnt_q + CW'(1) : '0;
  assign expire = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  // Contention goes to the port that did not win last time.
  assign winner = (s0_valid && s1_valid) ? ~last_q : s1_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    m_valid     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          grant_d = winner;
          last_d  = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        m_valid = 1'b1;
        busy    = 1'b1;
        if (m_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (expire) begin
          done        = 1'b1;
          timeout_err = ~reset;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A completion coinciding with reset is dropped along with the transaction.
  assign s0_ready = done && !reset && !grant_q;
  assign s1_ready = done && !reset &&  grant_q;
  assign s0_rdata = timeout_err ? '0 : m_rdata;
  assign s1_rdata = timeout_err ? '0 : m_rdata;

  assign m_addr   = grant_q ? s1_addr  : s0_addr;
  assign m_wdata  = grant_q ? s1_wdata : s0_wdata;
  assign m_wstrb  = grant_q ? s1_wstrb : s0_wstrb;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed per-cycle vector bench for sdram_port_arbiter, plus watchdog sequence.
module tb_sdram_port_arbiter;
  localparam int AW = 21;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
  localparam int NV = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          s0_valid, s1_valid, s0_ready, s1_ready;
  logic [AW-1:0] s0_addr, s1_addr, m_addr;
  logic [DW-1:0] s0_wdata, s1_wdata, s0_rdata, s1_rdata, m_wdata, m_rdata;
  logic [SW-1:0] s0_wstrb, s1_wstrb, m_wstrb;
  logic          m_valid, m_ready, grant_id, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_wstrb(s0_wstrb), .s0_rdata(s0_rdata),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_wstrb(s1_wstrb), .s1_rdata(s1_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic          rst, v0, v1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] wd0, wd1;
    logic [SW-1:0] ws0, ws1;
    logic          mr;
    logic [DW-1:0] mrd;
    logic          e_mv, e_busy, e_gid, e_r0, e_r1;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mwd;
    logic [SW-1:0] e_mws;
  } vec_t;

  vec_t vec [NV];

  function automatic vec_t mkv(logic rst, logic v0, logic v1, logic [AW-1:0] a0, logic [AW-1:0] a1,
                               logic mr, logic [DW-1:0] mrd, logic e_mv, logic e_busy,
                               logic e_gid, logic e_r0, logic e_r1, logic [AW-1:0] e_maddr);
    vec_t r;
    r.rst = rst; r.v0 = v0; r.v1 = v1; r.a0 = a0; r.a1 = a1;
    r.wd0 = '0; r.wd1 = '0; r.ws0 = '0; r.ws1 = '0;
    r.mr = mr; r.mrd = mrd;
    r.e_mv = e_mv; r.e_busy = e_busy; r.e_gid = e_gid; r.e_r0 = e_r0; r.e_r1 = e_r1;
    r.e_maddr = e_maddr; r.e_mwd = '0; r.e_mws = '0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; s0_valid = v.v0; s1_valid = v.v1;
    s0_addr = v.a0; s1_addr = v.a1;
    s0_wdata = v.wd0; s1_wdata = v.wd1; s0_wstrb = v.ws0; s1_wstrb = v.ws1;
    m_ready = v.mr; m_rdata = v.mrd;
  endtask

  initial begin
    vec_t idle;
    // Port 0 read, completion after five BUSY cycles
    vec[0]  = mkv(0, 1, 0, 'h123, 0, 0, 0,            0, 0, 0, 0, 0, 'h123);
    vec[1]  = mkv(0, 1, 0, 'h123, 0, 0, 0,            1, 1, 0, 0, 0, 'h123);
    vec[2]  = mkv(0, 1, 0, 'h123, 0, 0, 0,            1, 1, 0, 0, 0, 'h123);
    vec[3]  = mkv(0, 1, 0, 'h123, 0, 0, 0,            1, 1, 0, 0, 0, 'h123);
    vec[4]  = mkv(0, 1, 0, 'h123, 0, 0, 0,            1, 1, 0, 0, 0, 'h123);
    vec[5]  = mkv(0, 1, 0, 'h123, 0, 1, 'hDEADBEEF,   1, 1, 0, 1, 0, 'h123);
    vec[6]  = mkv(0, 0, 0, 'h123, 0, 0, 0,            0, 0, 0, 0, 0, 'h123);
    // Reset, then simultaneous requests and alternating grants
    vec[7]  = mkv(1, 0, 0, 'h0,   0, 0, 0,            0, 0, 0, 0, 0, 'h0);
    vec[8]  = mkv(0, 1, 1, 'h10, 'h20, 0, 0,          0, 0, 0, 0, 0, 'h10);
    vec[9]  = mkv(0, 1, 1, 'h10, 'h20, 1, 'hA,        1, 1, 0, 1, 0, 'h10);
    vec[10] = mkv(0, 0, 1, 'h10, 'h20, 0, 0,          0, 0, 0, 0, 0, 'h10);
    vec[11] = mkv(0, 1, 1, 'h10, 'h20, 1, 'hB,        1, 1, 1, 0, 1, 'h20);
    vec[12] = mkv(0, 1, 1, 'h10, 'h20, 0, 0,          0, 0, 1, 0, 0, 'h20);
    vec[13] = mkv(0, 1, 1, 'h10, 'h20, 1, 'hC,        1, 1, 0, 1, 0, 'h10);
    vec[14] = mkv(0, 1, 1, 'h10, 'h20, 0, 0,          0, 0, 0, 0, 0, 'h10);
    vec[15] = mkv(0, 1, 1, 'h10, 'h20, 1, 'hD,        1, 1, 1, 0, 1, 'h20);
    vec[16] = mkv(0, 1, 1, 'h10, 'h20, 0, 0,          0, 0, 1, 0, 0, 'h20);
    vec[17] = mkv(0, 1, 1, 'h10, 'h20, 1, 'hE,        1, 1, 0, 1, 0, 'h10);
    // Port 1 write with junk on idle port 0
    vec[18] = mkv(0, 0, 1, 'h10, 'h55, 0, 0,          0, 0, 0, 0, 0, 'h10);
    vec[19] = mkv(0, 0, 1, 'h10, 'h55, 0, 0,          1, 1, 1, 0, 0, 'h55);
    vec[20] = mkv(0, 0, 1, 'h10, 'h55, 1, 'hF0,       1, 1, 1, 0, 1, 'h55);
    vec[21] = mkv(0, 0, 0, 'h10, 'h55, 1, 'h11,       0, 0, 1, 0, 0, 'h55);
    for (int i = 18; i <= 21; i++) begin
      vec[i].wd0 = 32'hFFFFFFFF; vec[i].ws0 = 4'hF;
      vec[i].wd1 = 32'h12345678; vec[i].ws1 = 4'b0011;
      vec[i].e_mwd = (i == 18) ? 32'hFFFFFFFF : 32'h12345678;
      vec[i].e_mws = (i == 18) ? 4'hF : 4'b0011;
    end
    // Reset while port 1 owns the bus
    vec[22] = mkv(0, 0, 1, 'h10, 'h77, 0, 0,          0, 0, 1, 0, 0, 'h77);
    vec[23] = mkv(0, 0, 1, 'h10, 'h77, 0, 0,          1, 1, 1, 0, 0, 'h77);
    vec[24] = mkv(1, 0, 1, 'h10, 'h77, 0, 0,          1, 1, 1, 0, 0, 'h77);
    vec[25] = mkv(0, 0, 0, 'h10, 'h77, 0, 0,          0, 0, 0, 0, 0, 'h10);
    vec[26] = mkv(0, 1, 1, 'h10, 'h20, 0, 0,          0, 0, 0, 0, 0, 'h10);
    vec[27] = mkv(0, 1, 1, 'h10, 'h20, 0, 0,          1, 1, 0, 0, 0, 'h10);
    vec[28] = mkv(0, 1, 1, 'h10, 'h20, 1, 'h1234,     1, 1, 0, 1, 0, 'h10);
    vec[29] = mkv(0, 0, 0, 'h10, 'h20, 0, 0,          0, 0, 0, 0, 0, 'h10);

    idle = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_timeout_err", timeout_err, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i]);
      #1;
      chk($sformatf("v%0d_m_valid", i), m_valid, vec[i].e_mv);
      chk($sformatf("v%0d_busy", i), busy, vec[i].e_busy);
      chk($sformatf("v%0d_grant_id", i), grant_id, vec[i].e_gid);
      chk($sformatf("v%0d_s0_ready", i), s0_ready, vec[i].e_r0);
      chk($sformatf("v%0d_s1_ready", i), s1_ready, vec[i].e_r1);
      chk($sformatf("v%0d_m_addr", i), m_addr, vec[i].e_maddr);
      chk($sformatf("v%0d_m_wdata", i), m_wdata, vec[i].e_mwd);
      chk($sformatf("v%0d_m_wstrb", i), m_wstrb, vec[i].e_mws);
      chk($sformatf("v%0d_timeout_err", i), timeout_err, 0);
      chk($sformatf("v%0d_s0_rdata", i), s0_rdata, vec[i].mrd);
      chk($sformatf("v%0d_s1_rdata", i), s1_rdata, vec[i].mrd);
    end

    // Controller never answers a port 0 read
    @(negedge clk);
    drive(idle);
    @(negedge clk);
    reset = 0; s0_valid = 1; s0_addr = 'h200; m_rdata = 32'hCAFEF00D;
    #1;
    chk("wd_idle_m_valid", m_valid, 0);
`ifdef SDRAM_ARB_WATCHDOG_EN
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("wd_c%0d_busy", k), busy, 1);
      chk($sformatf("wd_c%0d_s0_ready", k), s0_ready, (k == TO));
      chk($sformatf("wd_c%0d_timeout_err", k), timeout_err, (k == TO));
      chk($sformatf("wd_c%0d_s1_ready", k), s1_ready, 0);
      if (k == TO) chk("wd_s0_rdata_zero", s0_rdata, 0);
    end
    @(negedge clk);
    s0_valid = 0;
    #1;
    chk("wd_after_m_valid", m_valid, 0);
    chk("wd_after_busy", busy, 0);
    chk("wd_after_timeout_err", timeout_err, 0);
`else
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("nowd_c%0d_busy", k), busy, 1);
      chk($sformatf("nowd_c%0d_s0_ready", k), s0_ready, 0);
      chk($sformatf("nowd_c%0d_timeout_err", k), timeout_err, 0);
    end
    @(negedge clk);
    m_ready = 1;
    #1;
    chk("nowd_final_s0_ready", s0_ready, 1);
    chk("nowd_final_s0_rdata", s0_rdata, 32'hCAFEF00D);
    @(negedge clk);
    m_ready = 0; s0_valid = 0;
    #1;
    chk("nowd_after_busy", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
